// File: rtl/calc_pkg.sv
// Shared constants for the calculator display path: active-low gfedcba
// segment patterns and digit-position names.
package calc_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        POS_ONES  = 2'd0,
        POS_TENS  = 2'd1,
        POS_HUNDS = 2'd2,
        POS_SIGN  = 2'd3
    } digit_pos_e;

endpackage

// File: rtl/bcd_seg_scan_seg_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern; any
// non-decimal nibble renders as a dash.
module seg_decode
    import calc_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    // Nibble lookup
    always_comb begin
        o_seg = SEG_DASH;
        case (i_nib)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed seven-segment driver: captures a packed BCD value
// on load and scans sign/hundreds/tens/ones with leading-zero blanking.
module bcd_seg_scan
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd,
    input  logic        neg,
    input  logic        err,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_idx;
    logic [11:0]   r_val;
    logic          r_neg_q;
    logic          r_err_q;
    logic          w_wrap;
    logic [3:0]    w_nib;
    logic [6:0]    w_dec;
    logic [6:0]    w_seg_next;

    assign w_wrap = (r_pcnt == PCNT_MAX);

    // Dwell prescaler and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_idx  <= 2'd0;
        end else if (w_wrap) begin
            r_pcnt <= '0;
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
            r_idx  <= r_idx;
        end
    end

    // Capture registers; the last load wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val   <= 12'h000;
            r_neg_q <= 1'b0;
            r_err_q <= 1'b0;
        end else if (load) begin
            r_val   <= bcd;
            r_neg_q <= neg;
            r_err_q <= err;
        end else begin
            r_val   <= r_val;
            r_neg_q <= r_neg_q;
            r_err_q <= r_err_q;
        end
    end

    // Nibble for the digit currently being scanned
    always_comb begin
        w_nib = 4'd0;
        case (r_idx)
            POS_ONES:  w_nib = r_val[3:0];
            POS_TENS:  w_nib = r_val[7:4];
            POS_HUNDS: w_nib = r_val[11:8];
            default:   w_nib = 4'd0;
        endcase
    end

    seg_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

    // Error and invalid-nibble dashes take priority over zero blanking
    always_comb begin
        w_seg_next = w_dec;
        if (r_err_q) begin
            w_seg_next = SEG_DASH;
        end else if (r_idx == POS_SIGN) begin
            w_seg_next = r_neg_q ? SEG_DASH : SEG_BLANK;
        end else if (w_nib > 4'd9) begin
            w_seg_next = SEG_DASH;
        end else if ((r_idx == POS_TENS) && (r_val[7:4] == 4'd0) && (r_val[11:8] == 4'd0)) begin
            w_seg_next = SEG_BLANK;
        end else if ((r_idx == POS_HUNDS) && (r_val[11:8] == 4'd0)) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = w_dec;
        end
    end

    // Registered pin drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= 4'b1111;
        end else begin
            seg <= w_seg_next;
            an  <= ~(4'b0001 << r_idx);
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan with SCAN_DIV = 4: a frame-position model
// predicts each cycle's pins, a negedge monitor compares.
module tb_bcd_seg_scan;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bcd = 12'h000;
    logic        neg = 1'b0;
    logic        err = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;

    int total = 0;
    int bad   = 0;

    bcd_seg_scan #(.SCAN_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .bcd  (bcd),
        .neg  (neg),
        .err  (err),
        .load (load),
        .seg  (seg),
        .an   (an)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // model state: cycle position within the frame plus captured value
    int          m_pos = 0;
    logic [11:0] m_val = 12'h000;
    bit          m_neg = 1'b0;
    bit          m_err = 1'b0;
    logic [10:0] q [$];

    function automatic logic [10:0] expect_out(int pos, logic [11:0] v, bit n, bit e);
        int d [3];
        int p;
        int sig;
        logic [6:0] s;
        logic [3:0] a;
        p = pos / DIV;
        d[0] = int'(v[3:0]);
        d[1] = int'(v[7:4]);
        d[2] = int'(v[11:8]);
        sig = (d[2] != 0) ? 3 : ((d[1] != 0) ? 2 : 1);
        a = 4'(15 - (1 << p));
        if (e)             s = 7'h3F;
        else if (p == 3)   s = n ? 7'h3F : 7'h7F;
        else if (d[p] > 9) s = 7'h3F;
        else if (p >= sig) s = 7'h7F;
        else               s = pat[d[p]];
        return {a, s};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            q.push_back(expect_out(m_pos, m_val, m_neg, m_err));
            if (load) begin
                m_val = bcd;
                m_neg = neg;
                m_err = err;
            end
            m_pos = (m_pos + 1) % (4 * DIV);
        end
    end

    task automatic check(string name, logic [10:0] got, logic [10:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got an=%b seg=%h, want an=%b seg=%h at %0t",
                     name, got[10:7], got[6:0], want[10:7], want[6:0], $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst || q.size() == 0) check("reset_pins", {an, seg}, {4'b1111, 7'h7F});
        else check("scan", {an, seg}, q.pop_front());
    end

    task automatic wait_pos(int pos);
        int n = 0;
        while (m_pos != pos && n < 64) begin
            @(posedge clk); #2;
            n++;
        end
        if (m_pos != pos) begin
            total++;
            bad++;
            $display("FAIL wait_pos: pos=%0d, want %0d", m_pos, pos);
        end
    endtask

    task automatic load_now(logic [11:0] b, bit n, bit e);
        bcd = b; neg = n; err = e; load = 1'b1;
        @(posedge clk); #2;
        load = 1'b0;
    endtask

    task automatic load_at(int pos, logic [11:0] b, bit n, bit e);
        wait_pos(pos);
        load_now(b, n, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        m_pos = 0; m_val = 12'h000; m_neg = 1'b0; m_err = 1'b0;
        #1;
        check("async_reset", {an, seg}, {4'b1111, 7'h7F});
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic frames(int n);
        repeat (n * 4 * DIV) @(posedge clk);
        #2;
    endtask

    function automatic logic [11:0] rand_bcd();
        logic [11:0] v;
        v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 7) == 0) v[4 * $urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
        if ($urandom_range(0, 2) == 0) v[11:8] = 4'd0;
        if ($urandom_range(0, 3) == 0) v[7:4] = 4'd0;
        return v;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        frames(1);
        // mid-scan reset
        repeat (6) @(posedge clk);
        #2;
        do_reset();
        frames(1);
        load_now(12'h007, 1'b0, 1'b0); frames(1);
        load_now(12'h105, 1'b0, 1'b0); frames(1);
        load_now(12'h042, 1'b1, 1'b0); frames(1);
        load_now(12'h000, 1'b1, 1'b0); frames(1);
        load_now(12'h999, 1'b0, 1'b1); frames(1);
        load_now(12'h123, 1'b0, 1'b0); frames(1);
        load_now(12'h1A3, 1'b0, 1'b0); frames(1);
        load_now(12'h0B0, 1'b0, 1'b0); frames(1);
        load_at(13, 12'h255, 1'b0, 1'b0);
        load_at(2, 12'h128, 1'b0, 1'b0);
        frames(1);
        // back-to-back loads
        load_now(12'h111, 1'b1, 1'b0);
        load_now(12'h222, 1'b0, 1'b1);
        load_now(12'h340, 1'b0, 1'b0);
        frames(1);
        for (int i = 0; i < 60; i++) begin
            load_at($urandom_range(0, 4 * DIV - 1), rand_bcd(),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #2;
            if (i == 30) do_reset();
        end
        frames(1);
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Multiplexed four-digit seven-segment display driver for the calculator datapath. It consumes the 12-bit packed BCD result produced by the binary-to-BCD converter, together with sign and error flags. It latches the value on a load strobe and time-multiplexes it onto a common digit bus with leading-zero blanking. It is the last stage before the board pins.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit is lit; legal range ≥ 2.
- `clk  in  1`: the single clock; all state is updated on its rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `bcd  in  12`: packed BCD value. `[11:8]` hundreds, `[7:4]` tens, `[3:0]` ones.
- `neg  in  1`: the value is negative; show a minus sign.
- `err  in  1`: calculator error or overflow.
- `load  in  1`: single-cycle strobe; capture `bcd`, `neg` and `err`.
- `seg  out  7`: segment drive, active-low, bit order gfedcba (bit 6 = g).
- `an  out  4`: digit enables, active-low. `an[0]` is ones, `an[1]` tens, `an[2]` hundreds, `an[3]` sign.

## Operation
- **Capture registers** `val`, `neg_q`, `err_q`.
  - Loaded only when `load` = 1.
  - Held otherwise.
  - Reset to 0.
- **Prescaler** `pcnt`, range 0..`SCAN_DIV`-1.
  - Increments every cycle.
  - At `SCAN_DIV`-1 it wraps to 0 and the digit index `idx` (2 bits) advances 0→1→2→3→0.
- **Digit content** for the current `idx`, in priority order:
  - `err_q` = 1: every position shows dash.
  - Nibble > 9 (invalid BCD): dash in that position only.
  - idx 0 (ones): always the digit, never blanked.
  - idx 1 (tens): blank if tens = 0 and hundreds = 0.
  - idx 2 (hundreds): blank if hundreds = 0.
  - idx 3: dash if `neg_q` = 1, else blank.
- **Segment patterns** (active-low hex, gfedcba):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
  - dash = 3F, blank = 7F
- **Digit enable:** `an` = ~(1 << idx). The enable stays asserted even for blank digits; blanking is done through `seg` = 7F.
- **No zero suppression of the sign:** `neg` with value 0 shows "-  0".

## Timing
- **Reset values** (asynchronous; apply immediately on `rst` assertion):
  - `seg` = 7F, `an` = 1111.
  - `pcnt` = 0, `idx` = 0.
  - `val` = 0, `neg_q` = 0, `err_q` = 0.
- **Registered outputs:** `seg` and `an` are registered. They reflect the `idx` and capture registers as they stood in the previous cycle, giving a latency of 1 cycle.
- **First cycle after reset release:** `an` = 1110 and `seg` = 40 (ones digit showing 0).
- **Dwell time:** each digit is lit for exactly `SCAN_DIV` cycles; a full frame is 4·`SCAN_DIV` cycles.
- **Load during a scan:**
  - Captured on the edge where `load` = 1.
  - Visible on `seg` the following cycle, mid-dwell.
  - The scan position is not disturbed.
- **Back-to-back loads:** the last load wins; no loads are queued.
- **Reset mid-scan:** counters return to 0 and the display content is lost.
- **Wrap condition:** exactly at `pcnt` = `SCAN_DIV`-1, no earlier or later.

## Structure
- **Shared package `calc_pkg`:**
  - Segment pattern constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`.
  - `NUM_DIGITS` = 4.
- **Sub-module `seg_decode`:** purely combinational 4-bit nibble → 7-bit pattern, with dash output for inputs > 9. It is instantiated once, on the muxed nibble.
- **Top level:** the prescaler, the index counter, the capture registers, the blank/priority logic and the output registers all live in `bcd_seg_scan`.

## Test plan
All scenarios use `SCAN_DIV` = 4.
1. **Reset.** Assert `rst` mid-scan → `seg` = 7F and `an` = 1111 immediately. After release, `an` = 1110 and `seg` = 40 for 4 cycles, then `an` = 1101.
2. **Leading-zero blanking.** Load `bcd` = 0x007, `neg` = 0 → over one frame, ones = 78 and tens/hundreds/sign = 7F. Load 0x105 → hundreds = 79, tens = 40, ones = 12.
3. **Sign.** Load `bcd` = 0x042, `neg` = 1 → sign digit = 3F, hundreds = 7F, tens = 19, ones = 24.
4. **Error.** Load with `err` = 1 and any `bcd` → all four digits show 3F for a full frame. A later load with `err` = 0 restores normal digits.
5. **Invalid nibble.** Load `bcd` = 0x1A3 → hundreds = 79, tens = 3F, ones = 30.
6. **Load mid-dwell.** While idx = 0, change from 0x255 to 0x128 at dwell cycle 2 → `seg` changes from 12 to 00 one cycle later, and `an` holds 1110 for the full 4-cycle dwell.
